// File: rtl/pc_pkg.sv
// Shared types and charset helpers for the parallel password cracker.
package pc_pkg;

  localparam int unsigned CHARSET_SIZE = 36;
  localparam logic [5:0]  BAD_IDX      = 6'd63;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [7:0] idx_to_char(input logic [5:0] idx);
    if (idx < 6'd10) return 8'h30 + 8'(idx);
    return 8'h61 + 8'(idx - 6'd10);
  endfunction

  function automatic logic [5:0] char_to_idx(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return 6'(c - 8'h30);
    if (c >= 8'h61 && c <= 8'h7a) return 6'(c - 8'h61 + 8'd10);
    return BAD_IDX;
  endfunction

endpackage

// File: rtl/password_cracker_par_lane.sv
// One comparator lane: registers its candidate and mask, then compares against the target.
module pc_lane
  import pc_pkg::*;
#(
  parameter int unsigned PW_LEN = 4,
  parameter int unsigned LOW_W  = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [7:0]          first,
  input  logic [5:0]          to,
  input  logic [LOW_W-1:0]    low,
  input  logic [8*PW_LEN-1:0] target,
  output logic [8*PW_LEN-1:0] cand,
  output logic                live,
  output logic                hit_c
);

  logic [8*PW_LEN-1:0] cand_d;
  logic                live_d;

  // Low digit j (least significant first) maps to character PW_LEN-1-j.
  always_comb begin
    cand_d = '0;
    for (int j = 0; j < int'(PW_LEN) - 1; j++) begin
      cand_d[8*j +: 8] = idx_to_char(low[6*j +: 6]);
    end
    cand_d[8*(PW_LEN-1) +: 8] = idx_to_char(first[5:0]);
    live_d = load && (first <= 8'(to));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand <= '0;
      live <= 1'b0;
    end else begin
      live <= live_d;
      if (load) cand <= cand_d;
    end
  end

  assign hit_c = live && (cand == target);

endmodule

// File: rtl/password_cracker_par.sv
// Multi-lane brute-force cracker: FSM, shared odometer, priority select and attempt counter.
module password_cracker_par
  import pc_pkg::*;
#(
  parameter int unsigned PW_LEN = 4,
  parameter int unsigned LANES  = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [8*PW_LEN-1:0] password_to_crack,
  input  logic [5:0]          from,
  input  logic [5:0]          to,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [8*PW_LEN-1:0] cracked_password,
  output logic [CNT_W-1:0]    attempts
);

  localparam int unsigned PW_W  = 8 * PW_LEN;
  localparam int unsigned LOW_N = (PW_LEN > 1) ? PW_LEN - 1 : 1;
  localparam int unsigned LOW_W = 6 * LOW_N;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [5:0]  MAX_IDX = 6'(CHARSET_SIZE - 1);

  state_t            state_q, state_d;
  logic              busy_d, done_d, found_d;
  logic [PW_W-1:0]   cracked_d;
  logic [CNT_W-1:0]  attempts_d;
  logic [PW_W-1:0]   target_q, target_d;
  logic [5:0]        to_q, to_d;
  logic              target_ok_q, target_ok_d;
  logic [LOW_W-1:0]  low_q, low_d;
  logic [7:0]        base_q, base_d;
  logic              issuing_q, issuing_d;
  logic              gen_valid_q, gen_valid_d;
  logic              gen_last_q, gen_last_d;
  logic              aborting_q, aborting_d;
  logic              inv_pend_q, inv_pend_d;

  logic              lane_load;
  logic [PW_W-1:0]   lane_cand [LANES];
  logic [LANES-1:0]  lane_live;
  logic [LANES-1:0]  lane_hit;

  logic              carry, low_max, odo_last, hit_any, tgt_ok;
  logic [7:0]        lane_cnt;
  logic [PW_W-1:0]   hit_cand;
  logic [SUM_W-1:0]  att_sum;
  logic [CNT_W-1:0]  att_inc;

  // Lane k of the current group tests first-character index base_q + k.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pc_lane #(.PW_LEN(PW_LEN), .LOW_W(LOW_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load   (lane_load),
      .first  (base_q + 8'(k)),
      .to     (to_q),
      .low    (low_q),
      .target (target_q),
      .cand   (lane_cand[k]),
      .live   (lane_live[k]),
      .hit_c  (lane_hit[k])
    );
  end

  always_comb begin
    state_d     = state_q;
    found_d     = found;
    cracked_d   = cracked_password;
    attempts_d  = attempts;
    target_d    = target_q;
    to_d        = to_q;
    target_ok_d = target_ok_q;
    low_d       = low_q;
    base_d      = base_q;
    issuing_d   = issuing_q;
    gen_valid_d = gen_valid_q;
    gen_last_d  = gen_last_q;
    aborting_d  = aborting_q;
    inv_pend_d  = inv_pend_q;
    lane_load   = 1'b0;

    // Odometer increment, least-significant digit in the low bits.
    carry   = 1'b1;
    low_max = 1'b1;
    for (int j = 0; j < int'(PW_LEN) - 1; j++) begin
      if (low_q[6*j +: 6] != MAX_IDX) low_max = 1'b0;
      if (carry) begin
        if (low_q[6*j +: 6] == MAX_IDX) begin
          low_d[6*j +: 6] = '0;
        end else begin
          low_d[6*j +: 6] = low_q[6*j +: 6] + 6'd1;
          carry = 1'b0;
        end
      end
    end
    odo_last = low_max && ((base_q + 8'(LANES)) > 8'(to_q));

    // Lowest-numbered hitting lane wins.
    lane_cnt = '0;
    hit_any  = 1'b0;
    hit_cand = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      lane_cnt = lane_cnt + 8'(lane_live[k]);
      if (lane_hit[k] && target_ok_q && !hit_any) begin
        hit_any  = 1'b1;
        hit_cand = lane_cand[k];
      end
    end
    att_sum = SUM_W'(attempts) + SUM_W'(lane_cnt);
    att_inc = att_sum[CNT_W] ? '1 : att_sum[CNT_W-1:0];

    tgt_ok = 1'b1;
    for (int c = 0; c < int'(PW_LEN); c++) begin
      if (char_to_idx(password_to_crack[8*c +: 8]) == BAD_IDX) tgt_ok = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (inv_pend_q) begin
          inv_pend_d = 1'b0;
          state_d    = DONE;
        end else if (start) begin
          target_d    = password_to_crack;
          to_d        = to;
          target_ok_d = tgt_ok;
          found_d     = 1'b0;
          cracked_d   = '0;
          attempts_d  = '0;
          low_d       = '0;
          base_d      = 8'(from);
          gen_valid_d = 1'b0;
          gen_last_d  = 1'b0;
          aborting_d  = 1'b0;
          if (from <= to && to <= MAX_IDX) begin
            issuing_d = 1'b1;
            state_d   = RUN;
          end else begin
            inv_pend_d = 1'b1;
          end
        end
      end
      RUN: begin
        lane_load   = issuing_q;
        gen_valid_d = issuing_q;
        gen_last_d  = issuing_q && odo_last;
        if (issuing_q) begin
          if (carry) base_d = base_q + 8'(LANES);
          if (odo_last) issuing_d = 1'b0;
        end
        // A pending abort discards whatever compare is in flight.
        if (aborting_q) begin
          state_d = DONE;
        end else if (abort) begin
          aborting_d = 1'b1;
        end else if (gen_valid_q) begin
          attempts_d = att_inc;
          if (hit_any) begin
            found_d   = 1'b1;
            cracked_d = hit_cand;
            state_d   = DONE;
          end else if (gen_last_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      found            <= 1'b0;
      cracked_password <= '0;
      attempts         <= '0;
      target_q         <= '0;
      to_q             <= '0;
      target_ok_q      <= 1'b0;
      low_q            <= '0;
      base_q           <= '0;
      issuing_q        <= 1'b0;
      gen_valid_q      <= 1'b0;
      gen_last_q       <= 1'b0;
      aborting_q       <= 1'b0;
      inv_pend_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      busy             <= busy_d;
      done             <= done_d;
      found            <= found_d;
      cracked_password <= cracked_d;
      attempts         <= attempts_d;
      target_q         <= target_d;
      to_q             <= to_d;
      target_ok_q      <= target_ok_d;
      low_q            <= low_d;
      base_q           <= base_d;
      issuing_q        <= issuing_d;
      gen_valid_q      <= gen_valid_d;
      gen_last_q       <= gen_last_d;
      aborting_q       <= aborting_d;
      inv_pend_q       <= inv_pend_d;
    end
  end

endmodule

// File: doc/password_cracker_par.md
# password_cracker_par

Parametrised, multi-lane brute-force password cracker; next generation of `password_cracker`. It searches PW_LEN-character ASCII candidates over a fixed 36-symbol charset, restricted to a `from`..`to` range of the first-character index, with LANES candidates compared per cycle. A start/done handshake and abort let a host or top-level partitioner launch and collect searches. Results, found flag and attempt count stay held until the next start.

## Interface

- PW_LEN, 4, password length in characters (1..8)
- LANES, 2, parallel comparators; lane k owns first-character indices from+k, from+k+LANES, …
- CNT_W, 32, width of attempt counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  launch search; sampled only when busy=0
- abort  in  1  terminate running search
- password_to_crack  in  8*PW_LEN  target ASCII; char 0 in MSBs; latched at start
- from  in  6  first-character start index; latched at start
- to  in  6  first-character end index, inclusive; latched at start
- busy  out  1  search in progress
- done  out  1  one-cycle pulse at search end
- found  out  1  match found (held)
- cracked_password  out  8*PW_LEN  matching candidate (held; 0 when found=0)
- attempts  out  CNT_W  lane-candidates tested (held, saturating)

## Operation

- Charset index 0..9 = '0'..'9', 10..35 = 'a'..'z'. Index-to-ASCII conversion is combinational per character.
- Candidate = first-char index + (PW_LEN-1) low digits, base 36.
- Step s: low odometer value L = s mod 36^(PW_LEN-1); group g = s div 36^(PW_LEN-1). Lane k first char = from + g*LANES + k. A lane is masked when that index exceeds `to`.
- Low odometer increments by 1 per step, least-significant digit last. Its wrap carries into g.
- FSM: IDLE -> RUN (start, valid range) -> DONE (hit, exhaustion or abort) -> IDLE. DONE lasts one cycle; `done` is asserted only in DONE.
- Hit: the registered compare of any unmasked lane equals the target. The lowest-numbered hitting lane wins. found=1, cracked_password=its candidate.
- Exhaustion: last step compared with no hit -> found=0.
- attempts: sum of unmasked lanes over all compared steps, including the hit step. Cleared at start; saturates at all-ones.
- Invalid range (from>to or to>35): IDLE -> DONE directly, found=0, attempts=0.
- Target characters outside the charset never match; the search runs to exhaustion.
- abort in RUN: DONE next cycle, found=0, attempts keeps its count so far. abort in IDLE/DONE is ignored. abort wins over a simultaneous hit.
- start while busy=1 or in DONE: ignored.

## Timing

- Reset: state IDLE, busy=0, done=0, found=0, cracked_password=0, attempts=0, odometer/group=0.
- Start sampled at edge E0 -> busy=1 after E0. Step s is held in the generate register after E(s+1). Its compare is registered at E(s+2).
- Hit on step s: done=1, found valid, busy=0 after edge E(s+2).
- Exhaustion with S total steps, S = ceil((to-from+1)/LANES)*36^(PW_LEN-1): done after E(S+1).
- Invalid range: done after E1; busy stays 0.
- abort sampled at edge Ea in RUN: done after Ea+1. The in-flight compare is discarded.
- Throughput: one step per cycle, with no bubbles between groups.
- rst low at any time: immediate return to reset values. No done pulse is generated.

## Structure

- Package `pc_pkg`:
  - CHARSET_SIZE=36.
  - functions `idx_to_char` and `char_to_idx` (returns 63 for non-charset).
  - FSM state enum {IDLE, RUN, DONE}.
- Sub-module `pc_lane`: builds one candidate from first-char index and shared low digits, plus a registered equality compare and mask. It is instantiated LANES times.
- Top level holds:
  - the FSM
  - the low odometer and group counter
  - the priority select
  - the attempts counter

## Test plan

- PW_LEN=4, LANES=2, target "0001", from=0, to=35, start at E0 -> done after E3, found=1, cracked_password="0001", attempts=4.
- Target "zzzz", from=0, to=35 -> done after E839809, found=1, attempts=1679616.
- Target "a000", from=11, to=35 (first char outside range) -> exhaustion, found=0, attempts=25*46656, done after E(13*46656+1).
- from=20, to=5 -> done after E1, found=0, busy never high. Also: target "0#00" -> exhaustion, found=0.
- Abort at step 100 of a "zzzz" search -> done one cycle later, found=0, attempts nonzero and held. start pulsed during RUN is ignored.
- rst low mid-search -> all outputs 0 immediately, no done pulse. A new start afterwards finds "0001" with the E3 latency.
